// File: rtl/cache_arb_pkg.sv
// Shared types and sizing for the L1-to-L2 request arbiter.
// Holds the FSM state encoding, grant identifiers, line geometry and the
// L2 request payload struct used by l2_request_arbiter.
package cache_arb_pkg;

  localparam int unsigned s_offset = 5;                  // log2 bytes per line
  localparam int unsigned s_index  = 3;                  // index bits
  localparam int unsigned s_line   = 8 * (2 ** s_offset);  // line width in bits
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned PERF_W   = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  localparam logic INSN = 1'b0;
  localparam logic DATA = 1'b1;

  typedef struct packed {
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [s_line-1:0] wdata;
  } l2_req_t;

  // Set index of a line address.
  function automatic logic [s_index-1:0] line_index(input logic [ADDR_W-1:0] addr);
    return addr[s_offset +: s_index];
  endfunction

endpackage

// File: rtl/arb_perf_counters.sv
// Saturating 32-bit event counters for the L2 request arbiter.
// Ports:
//   clk, rst       clock, synchronous active-high reset (clears all counters)
//   i_grant_i      strobe: icache granted this cycle
//   i_grant_d      strobe: dcache granted this cycle
//   i_conflict     strobe: both requesters pending in IDLE this cycle
//   o_i_grants     icache grant count
//   o_d_grants     dcache grant count
//   o_conflicts    conflict cycle count
module arb_perf_counters
  import cache_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_grant_i,
  input  logic              i_grant_d,
  input  logic              i_conflict,
  output logic [PERF_W-1:0] o_i_grants,
  output logic [PERF_W-1:0] o_d_grants,
  output logic [PERF_W-1:0] o_conflicts
);

  logic [PERF_W-1:0] r_i_grants;
  logic [PERF_W-1:0] r_d_grants;
  logic [PERF_W-1:0] r_conflicts;

  // Increment unless already at the all-ones ceiling.
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + PERF_W'(1) : v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_i_grants  <= '0;
      r_d_grants  <= '0;
      r_conflicts <= '0;
    end else begin
      r_i_grants  <= sat_inc(r_i_grants, i_grant_i);
      r_d_grants  <= sat_inc(r_d_grants, i_grant_d);
      r_conflicts <= sat_inc(r_conflicts, i_conflict);
    end
  end

  assign o_i_grants  = r_i_grants;
  assign o_d_grants  = r_d_grants;
  assign o_conflicts = r_conflicts;

endmodule

// File: rtl/l2_request_arbiter.sv
// Registered-grant arbiter sharing one L2 port between the L1 icache and
// dcache miss paths. A grant is taken in IDLE, held until l2_resp, and ties
// are broken round-robin against the last granted requester. L2-side outputs
// depend only on the state register and the granted requester, never on l2_resp.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   i_read/i_write/i_address/i_wdata   icache miss request (held until i_resp)
//   i_resp/i_rdata                 icache completion pulse and fill data
//   d_read/d_write/d_address/d_wdata   dcache miss request (held until d_resp)
//   d_resp/d_rdata                 dcache completion pulse and fill data
//   l2_read/l2_write/l2_address/l2_wdata  request to L2
//   l2_resp/l2_rdata               L2 completion pulse and read data
//   perf_i_grants/perf_d_grants/perf_conflicts  event counters
// Build option: define ARB_PERF_EN to build the counters; otherwise perf_* read 0.
module l2_request_arbiter
  import cache_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [s_line-1:0] i_wdata,
  output logic              i_resp,
  output logic [s_line-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [s_line-1:0] d_wdata,
  output logic              d_resp,
  output logic [s_line-1:0] d_rdata,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [s_line-1:0] l2_wdata,
  input  logic              l2_resp,
  input  logic [s_line-1:0] l2_rdata,
  output logic [PERF_W-1:0] perf_i_grants,
  output logic [PERF_W-1:0] perf_d_grants,
  output logic [PERF_W-1:0] perf_conflicts
);

  arb_state_t r_state;
  arb_state_t w_next_state;
  logic       r_last_grant;
  logic       w_i_pend;
  logic       w_d_pend;
  logic       w_grant_i;
  logic       w_grant_d;
  l2_req_t    w_l2_req;

  assign w_i_pend = i_read | i_write;
  assign w_d_pend = d_read | d_write;

  // State and round-robin history registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= DATA;
    end else begin
      r_state <= w_next_state;
      if (w_grant_i) begin
        r_last_grant <= INSN;
      end else if (w_grant_d) begin
        r_last_grant <= DATA;
      end
    end
  end

  // Next-state, grant decision and output muxing.
  always_comb begin
    w_next_state = r_state;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    w_l2_req     = '0;
    i_resp       = 1'b0;
    i_rdata      = '0;
    d_resp       = 1'b0;
    d_rdata      = '0;
    case (r_state)
      IDLE: begin
        // On a tie the icache wins only if the dcache had the last grant.
        if (w_i_pend && (!w_d_pend || (r_last_grant == DATA))) begin
          w_grant_i    = 1'b1;
          w_next_state = SERVE_I;
        end else if (w_d_pend) begin
          w_grant_d    = 1'b1;
          w_next_state = SERVE_D;
        end
      end
      SERVE_I: begin
        w_l2_req = '{read: i_read, write: i_write, address: i_address, wdata: i_wdata};
        if (l2_resp) begin
          i_resp       = 1'b1;
          i_rdata      = l2_rdata;
          w_next_state = IDLE;
        end
      end
      SERVE_D: begin
        w_l2_req = '{read: d_read, write: d_write, address: d_address, wdata: d_wdata};
        if (l2_resp) begin
          d_resp       = 1'b1;
          d_rdata      = l2_rdata;
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  assign l2_read    = w_l2_req.read;
  assign l2_write   = w_l2_req.write;
  assign l2_address = w_l2_req.address;
  assign l2_wdata   = w_l2_req.wdata;

`ifdef ARB_PERF_EN
  logic w_conflict;

  assign w_conflict = (r_state == IDLE) && w_i_pend && w_d_pend;

  arb_perf_counters u_perf (
    .clk         (clk),
    .rst         (rst),
    .i_grant_i   (w_grant_i),
    .i_grant_d   (w_grant_d),
    .i_conflict  (w_conflict),
    .o_i_grants  (perf_i_grants),
    .o_d_grants  (perf_d_grants),
    .o_conflicts (perf_conflicts)
  );
`else
  assign perf_i_grants  = '0;
  assign perf_d_grants  = '0;
  assign perf_conflicts = '0;
`endif

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Self-checking bench for l2_request_arbiter: table of request vectors plus
// hand-written sequences for sustained contention, mid-transaction arrival
// and reset during a transaction. Expected L2 requests and responses are
// queued when stimulus is driven and checked as the DUT serves them.
module tb_l2_request_arbiter;
  import cache_arb_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_read, i_write, d_read, d_write;
  logic [31:0]       i_address, d_address;
  logic [s_line-1:0] i_wdata, d_wdata;
  logic              i_resp, d_resp;
  logic [s_line-1:0] i_rdata, d_rdata;
  logic              l2_read, l2_write;
  logic [31:0]       l2_address;
  logic [s_line-1:0] l2_wdata;
  logic              l2_resp;
  logic [s_line-1:0] l2_rdata;
  logic [31:0]       perf_i_grants, perf_d_grants, perf_conflicts;

  l2_request_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .i_read         (i_read),
    .i_write        (i_write),
    .i_address      (i_address),
    .i_wdata        (i_wdata),
    .i_resp         (i_resp),
    .i_rdata        (i_rdata),
    .d_read         (d_read),
    .d_write        (d_write),
    .d_address      (d_address),
    .d_wdata        (d_wdata),
    .d_resp         (d_resp),
    .d_rdata        (d_rdata),
    .l2_read        (l2_read),
    .l2_write       (l2_write),
    .l2_address     (l2_address),
    .l2_wdata       (l2_wdata),
    .l2_resp        (l2_resp),
    .l2_rdata       (l2_rdata),
    .perf_i_grants  (perf_i_grants),
    .perf_d_grants  (perf_d_grants),
    .perf_conflicts (perf_conflicts)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv, dv;      // requester present
    logic        iw, dw;      // 1 = write, 0 = read
    logic [31:0] ia, da;
    int unsigned lat;         // extra L2 cycles before l2_resp
    logic [7:0]  fill;        // icache fill byte; dcache gets ~fill
    logic        exp_first;   // expected first grant: 0 icache, 1 dcache
  } vec_t;

  typedef struct {
    logic          who;       // 0 icache, 1 dcache
    logic          read, write;
    logic [31:0]   addr;
    logic [255:0]  wdata, rdata;
    int unsigned   lat;
  } exp_t;

  exp_t        sb[$];
  vec_t        vt[8];
  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned exp_ig = 0, exp_dg = 0, exp_conf = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic who, input logic rd, input logic wr,
                              input logic [31:0] a, input logic [255:0] wd,
                              input logic [255:0] rdd, input int unsigned lat);
    exp_t e;
    e.who = who; e.read = rd; e.write = wr; e.addr = a;
    e.wdata = wd; e.rdata = rdd; e.lat = lat;
    return e;
  endfunction

  task automatic chk_perf(input string nm);
`ifdef ARB_PERF_EN
    chk({nm, "_perf_i"}, 256'(perf_i_grants), 256'(exp_ig));
    chk({nm, "_perf_d"}, 256'(perf_d_grants), 256'(exp_dg));
    chk({nm, "_perf_c"}, 256'(perf_conflicts), 256'(exp_conf));
`else
    chk({nm, "_perf_off"}, 256'({perf_i_grants, perf_d_grants, perf_conflicts}), 256'(0));
`endif
  endtask

  // Called just after a clock edge with the arbiter in IDLE and the
  // requester at the head of the scoreboard pending.
  task automatic serve_one(input logic rearm, input logic [31:0] rearm_addr);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_empty: got no queued entry want one");
      return;
    end
    e = sb.pop_front();
    @(negedge clk);
    chk("bubble", 256'({l2_read, l2_write}), 256'(2'b00));
    @(negedge clk);
    chk("grant_rw", 256'({l2_read, l2_write}), 256'({e.read, e.write}));
    chk("grant_addr", 256'(l2_address), 256'(e.addr));
    chk("grant_wdata", l2_wdata, e.wdata);
    for (int c = 0; c < int'(e.lat); c++) begin
      @(negedge clk);
      chk("hold", 256'({l2_read, l2_write, l2_address, i_resp, d_resp}),
          256'({e.read, e.write, e.addr, 2'b00}));
    end
    @(posedge clk); #1;
    l2_resp  = 1'b1;
    l2_rdata = e.rdata;
    @(negedge clk);
    if (e.who == 1'b0) begin
      chk("i_resp", 256'({i_resp, d_resp}), 256'(2'b10));
      chk("i_rdata", i_rdata, e.rdata);
      chk("d_rdata_idle", d_rdata, 256'(0));
    end else begin
      chk("d_resp", 256'({i_resp, d_resp}), 256'(2'b01));
      chk("d_rdata", d_rdata, e.rdata);
      chk("i_rdata_idle", i_rdata, 256'(0));
    end
    @(posedge clk); #1;
    l2_resp  = 1'b0;
    l2_rdata = '0;
    if (e.who == 1'b0) begin
      if (rearm) begin
        i_address = rearm_addr;
        i_wdata   = {8{rearm_addr}};
      end else begin
        i_read  = 1'b0;
        i_write = 1'b0;
      end
    end else begin
      if (rearm) begin
        d_address = rearm_addr;
        d_wdata   = {8{rearm_addr}};
      end else begin
        d_read  = 1'b0;
        d_write = 1'b0;
      end
    end
  endtask

  // A requester must hold its request until its own resp.
  logic i_owed = 1'b0;
  logic d_owed = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      i_owed <= 1'b0;
      d_owed <= 1'b0;
    end else begin
      a_i_hold: assert (!i_owed || i_read || i_write)
        else $error("FAIL i_hold: icache dropped request before i_resp");
      a_d_hold: assert (!d_owed || d_read || d_write)
        else $error("FAIL d_hold: dcache dropped request before d_resp");
      i_owed <= (i_read | i_write) & ~i_resp;
      d_owed <= (d_read | d_write) & ~d_resp;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    vt[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_1040, 32'h0000_3000, 2, 8'h11, 1'b0};
    vt[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1000, 32'h0,         5, 8'hA5, 1'b0};
    vt[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0,         32'h0000_2040, 1, 8'h22, 1'b1};
    vt[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_1080, 32'h0000_30C0, 3, 8'h33, 1'b0};
    vt[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_10A0, 32'h0000_3100, 0, 8'h44, 1'b0};
    vt[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_10E0, 32'h0,         0, 8'h55, 1'b0};
    vt[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_1120, 32'h0000_3140, 1, 8'h66, 1'b1};
    vt[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0000_3180, 2, 8'h77, 1'b1};

    rst = 1'b1;
    i_read = 1'b0; i_write = 1'b0; i_address = '0; i_wdata = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
    l2_resp = 1'b0; l2_rdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset: nothing asserted.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle_ctl", 256'({l2_read, l2_write, i_resp, d_resp, l2_address}), 256'(0));
      chk("idle_data", l2_wdata | i_rdata | d_rdata, 256'(0));
    end
    chk_perf("reset");

    // Table of single and contending requests.
    for (int k = 0; k < 8; k++) begin
      exp_t ei, ed;
      @(posedge clk); #1;
      ei = mk(1'b0, ~vt[k].iw, vt[k].iw, vt[k].ia, {8{vt[k].ia}}, {32{vt[k].fill}}, vt[k].lat);
      ed = mk(1'b1, ~vt[k].dw, vt[k].dw, vt[k].da, {8{vt[k].da}}, {32{~vt[k].fill}}, vt[k].lat);
      if (vt[k].iv) begin
        i_read = ~vt[k].iw; i_write = vt[k].iw; i_address = vt[k].ia; i_wdata = {8{vt[k].ia}};
      end
      if (vt[k].dv) begin
        d_read = ~vt[k].dw; d_write = vt[k].dw; d_address = vt[k].da; d_wdata = {8{vt[k].da}};
      end
      if (vt[k].exp_first == 1'b0) begin
        if (vt[k].iv) sb.push_back(ei);
        if (vt[k].dv) sb.push_back(ed);
      end else begin
        if (vt[k].dv) sb.push_back(ed);
        if (vt[k].iv) sb.push_back(ei);
      end
      if (vt[k].iv) exp_ig++;
      if (vt[k].dv) exp_dg++;
      if (vt[k].iv && vt[k].dv) exp_conf++;
      if (vt[k].iv) serve_one(1'b0, 32'h0);
      if (vt[k].dv) serve_one(1'b0, 32'h0);
    end
    chk_perf("table");

    // Sustained contention: each requester re-asserts right after its resp.
    @(posedge clk); #1;
    i_read = 1'b1; i_address = 32'h0000_4000; i_wdata = {8{32'h0000_4000}};
    d_read = 1'b1; d_address = 32'h0000_5000; d_wdata = {8{32'h0000_5000}};
    sb.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0000_4000, {8{32'h0000_4000}}, {32{8'h41}}, 1));
    sb.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0000_5000, {8{32'h0000_5000}}, {32{8'h51}}, 1));
    sb.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0000_4040, {8{32'h0000_4040}}, {32{8'h42}}, 1));
    sb.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0000_5040, {8{32'h0000_5040}}, {32{8'h52}}, 1));
    serve_one(1'b1, 32'h0000_4040);
    serve_one(1'b1, 32'h0000_5040);
    serve_one(1'b0, 32'h0);
    serve_one(1'b0, 32'h0);
    exp_ig += 2;
    exp_dg += 2;
    exp_conf += 3;
    chk_perf("contend");

    // Icache arrives while the dcache write is in flight.
    @(posedge clk); #1;
    d_write = 1'b1; d_address = 32'h0000_2020; d_wdata = {8{32'hDEAD_BEEF}};
    sb.push_back(mk(1'b1, 1'b0, 1'b1, 32'h0000_2020, {8{32'hDEAD_BEEF}}, {32{8'h5D}}, 0));
    @(negedge clk);
    chk("t5_bubble", 256'({l2_read, l2_write}), 256'(2'b00));
    @(negedge clk);
    chk("t5_grant", 256'({l2_read, l2_write, l2_address}), 256'({1'b0, 1'b1, 32'h0000_2020}));
    chk("t5_wdata", l2_wdata, {8{32'hDEAD_BEEF}});
    @(posedge clk); #1;
    i_read = 1'b1; i_address = 32'h0000_1100; i_wdata = {8{32'h0000_1100}};
    sb.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0000_1100, {8{32'h0000_1100}}, {32{8'h6E}}, 1));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t5_hold", 256'({l2_read, l2_write, l2_address, i_resp, d_resp}),
          256'({1'b0, 1'b1, 32'h0000_2020, 2'b00}));
    end
    @(posedge clk); #1;
    e = sb.pop_front();
    l2_resp = 1'b1; l2_rdata = e.rdata;
    @(negedge clk);
    chk("t5_d_resp", 256'({i_resp, d_resp}), 256'(2'b01));
    chk("t5_d_rdata", d_rdata, {32{8'h5D}});
    chk("t5_i_rdata", i_rdata, 256'(0));
    @(posedge clk); #1;
    l2_resp = 1'b0; l2_rdata = '0; d_write = 1'b0;
    serve_one(1'b0, 32'h0);
    exp_dg++;
    exp_ig++;
    chk_perf("midarrive");

    // Reset during a dcache transaction drops the late response.
    @(posedge clk); #1;
    d_read = 1'b1; d_address = 32'h0000_3300; d_wdata = '0;
    @(negedge clk);
    @(negedge clk);
    chk("t6_grant", 256'({l2_read, l2_address}), 256'({1'b1, 32'h0000_3300}));
    @(posedge clk); #1;
    rst = 1'b1; d_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_idle", 256'({l2_read, l2_write, l2_address, i_resp, d_resp}), 256'(0));
    @(posedge clk); #1;
    l2_resp = 1'b1; l2_rdata = {32{8'h99}};
    @(negedge clk);
    chk("t6_late_resp", 256'({i_resp, d_resp}), 256'(2'b00));
    chk("t6_late_rdata", d_rdata | i_rdata, 256'(0));
    @(posedge clk); #1;
    l2_resp = 1'b0; l2_rdata = '0;
    @(negedge clk);
    chk("t6_still_idle", 256'({l2_read, l2_write}), 256'(2'b00));
    exp_ig = 0;
    exp_dg = 0;
    exp_conf = 0;
    chk_perf("t6_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
